// File: rtl/data_memory_ctrl.sv
// Byte-addressable little-endian data memory with valid/ready requests and a fixed wait-state latency.
// Optional build macro DMEM_TRACE_EN prints one trace line per accepted request.
module data_memory_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] pend_rdata;
    logic        pend_err;

    logic [7:0]  mem [0:DEPTH_BYTES-1];

    logic          accept;
    logic          fault;
    logic [2:0]    nbytes;
    logic [32:0]   last_addr;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   load_data;

    assign req_ready = !rst && (state != S_WAIT);
    assign accept    = req_valid && req_ready;

    assign a0 = req_addr[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        nbytes = 3'd1;
        case (req_size)
            2'b01:   nbytes = 3'd2;
            2'b10:   nbytes = 3'd4;
            default: nbytes = 3'd1;
        endcase
    end

    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign last_addr = {1'b0, req_addr} + 33'(nbytes) - 33'd1;

    assign fault = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (last_addr >= 33'(DEPTH_BYTES));

    always_comb begin
        load_data = 32'h0;
        if (!fault && !req_we) begin
            case (req_size)
                2'b00:   load_data = {{24{b0[7] & ~req_unsigned}}, b0};
                2'b01:   load_data = {{16{b1[7] & ~req_unsigned}}, b1, b0};
                default: load_data = {b3, b2, b1, b0};
            endcase
        end
    end

    // NOTE: the storage array has no reset; contents must survive rst and a reset loop would not map to RAM.
    always_ff @(posedge clk) begin
        if (accept && !fault && req_we) begin
            mem[a0] <= req_wdata[7:0];
            if (req_size != 2'b00) begin
                mem[a1] <= req_wdata[15:8];
            end
            if (req_size == 2'b10) begin
                mem[a2] <= req_wdata[23:16];
                mem[a3] <= req_wdata[31:24];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            pend_rdata <= 32'h0;
            pend_err   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        if (WAIT_STATES == 0) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= load_data;
                            rsp_err   <= fault;
                        end else begin
                            state      <= S_WAIT;
                            cnt        <= WS_INIT;
                            pend_rdata <= load_data;
                            pend_err   <= fault;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_rdata;
                        rsp_err   <= pend_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DMEM_TRACE_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (accept) begin
                $display("%0d, %s Mem[%0d] size=%0d data=%0d%s", cycle_cnt,
                         req_we ? "W" : "R", req_addr, req_size,
                         req_we ? req_wdata : load_data, fault ? " FAULT" : "");
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a zero-wait and a three-wait instance checked against a byte-array model.
module tb_data_memory_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned model_mem [2][DEPTH];

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    function automatic int ws_of(input int sel);
        return (sel == 1) ? 3 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request on instance sel and checks latency, data and error against the model.
    task automatic access(input int sel, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er);
        int     n;
        int     idx;
        int     lat;
        bit     flt;
        longint v;
        logic [31:0] exp_rd;

        check("ready_before_req", {31'b0, req_ready[sel]}, 32'd1);
        req_we[sel]       = we;
        req_size[sel]     = size;
        req_unsigned[sel] = uns;
        req_addr[sel]     = addr;
        req_wdata[sel]    = wdata;
        req_valid[sel]    = 1'b1;

        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        flt = (size == 2'd3) || ((addr % n) != 0) || (longint'({32'h0, addr}) + n > DEPTH);
        exp_rd = 32'h0;
        if (!flt) begin
            idx = int'(addr);
            if (we) begin
                for (int i = 0; i < n; i++) model_mem[sel][idx + i] = wdata[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (longint'(model_mem[sel][idx + i]) << (8 * i));
                if (n < 4 && !uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
                exp_rd = v[31:0];
            end
        end

        @(posedge clk);
        @(negedge clk);
        req_valid[sel] = 1'b0;
        lat = 0;
        while (!rsp_valid[sel] && lat < 20) begin
            check("ready_in_wait", {31'b0, req_ready[sel]}, 32'd0);
            lat++;
            @(negedge clk);
        end
        check("rsp_timeout", {31'b0, rsp_valid[sel]}, 32'd1);
        check("latency", lat, ws_of(sel));
        check("rsp_rdata", rsp_rdata[sel], exp_rd);
        check("rsp_err", {31'b0, rsp_err[sel]}, {31'b0, flt});
        rd = rsp_rdata[sel];
        er = rsp_err[sel];
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [1:0]  sz;
        logic [31:0] ad;
        int          sel;
        int          r;

        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_we[s] = 1'b0; req_size[s] = 2'd0;
            req_unsigned[s] = 1'b0; req_addr[s] = 32'h0; req_wdata[s] = 32'h0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_rsp_valid", {31'b0, rsp_valid[s]}, 32'd0);
            check("reset_rsp_rdata", rsp_rdata[s], 32'h0);
            check("reset_rsp_err", {31'b0, rsp_err[s]}, 32'd0);
            check("ready_during_rst", {31'b0, req_ready[s]}, 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) check("ready_after_rst", {31'b0, req_ready[s]}, 32'd1);

        // Fill both memories so every later load has defined contents.
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < DEPTH / 4; w++) access(s, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, rd, er);
        @(negedge clk);

        // Back-to-back on the zero-wait instance.
        access(0, 1'b1, 2'd2, 1'b0, 32'd8, 32'h8040C0FF, rd, er);
        access(0, 1'b0, 2'd0, 1'b0, 32'd8, 32'h0, rd, er);
        check("t1_lb_signed", rd, 32'hFFFFFFFF);
        access(0, 1'b0, 2'd1, 1'b1, 32'd10, 32'h0, rd, er);
        check("t1_lh_unsigned", rd, 32'h00008040);
        @(negedge clk);
        check("t1_strobe_drops", {31'b0, rsp_valid[0]}, 32'd0);

        // Wait-state latency, byte merge and a misaligned store on the three-wait instance.
        access(1, 1'b1, 2'd2, 1'b0, 32'd8, 32'h8040C0FF, rd, er);
        access(1, 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, rd, er);
        check("t2_lw", rd, 32'h8040C0FF);
        access(1, 1'b1, 2'd0, 1'b0, 32'd9, 32'h0000005A, rd, er);
        access(1, 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, rd, er);
        check("t3_lw_merged", rd, 32'h80405AFF);
        access(1, 1'b1, 2'd1, 1'b0, 32'd9, 32'h0000BEEF, rd, er);
        check("t3_sh_misaligned_err", {31'b0, er}, 32'd1);
        access(1, 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, rd, er);
        check("t3_lw_unchanged", rd, 32'h80405AFF);

        // Range and encoding faults, plus the last legal addresses.
        access(0, 1'b0, 2'd2, 1'b0, 32'd1022, 32'h0, rd, er);
        check("t4_lw_1022_err", {31'b0, er}, 32'd1);
        check("t4_lw_1022_data", rd, 32'h0);
        access(0, 1'b0, 2'd2, 1'b0, 32'h00010000, 32'h0, rd, er);
        check("t4_lw_alias_err", {31'b0, er}, 32'd1);
        access(0, 1'b0, 2'd3, 1'b0, 32'd4, 32'h0, rd, er);
        check("t4_size11_err", {31'b0, er}, 32'd1);
        access(0, 1'b1, 2'd2, 1'b0, 32'd1020, 32'hCAFEF00D, rd, er);
        access(0, 1'b0, 2'd2, 1'b0, 32'd1020, 32'h0, rd, er);
        check("t4_lw_1020", rd, 32'hCAFEF00D);
        access(0, 1'b0, 2'd0, 1'b1, 32'd1023, 32'h0, rd, er);
        check("t4_lbu_1023", rd, 32'h000000CA);
        access(0, 1'b0, 2'd1, 1'b0, 32'd1022, 32'h0, rd, er);
        check("t4_lh_1022", rd, 32'hFFFFCAFE);
        access(0, 1'b1, 2'd0, 1'b0, 32'd1024, 32'h11, rd, er);
        check("t4_sb_1024_err", {31'b0, er}, 32'd1);
        access(0, 1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0, rd, er);
        check("t4_lb_top_err", {31'b0, er}, 32'd1);
        access(0, 1'b0, 2'd0, 1'b0, 32'd0, 32'h0, rd, er);

        // Reset during WAIT after an accepted store: no response, store kept.
        access(1, 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, rd, er);
        req_we[1] = 1'b1; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
        req_addr[1] = 32'd16; req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
        for (int i = 0; i < 4; i++) model_mem[1][16 + i] = 8'(32'h12345678 >> (8 * i));
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("t5_in_wait", {31'b0, req_ready[1]}, 32'd0);
        rst = 1'b1;
        #1;
        check("t5_rst_rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
        check("t5_rst_rsp_rdata", rsp_rdata[1], 32'h0);
        check("t5_rst_rsp_err", {31'b0, rsp_err[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_ready_after_rst", {31'b0, req_ready[1]}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_rsp", {31'b0, rsp_valid[1]}, 32'd0);
            check("t5_idle_ready", {31'b0, req_ready[1]}, 32'd1);
        end
        access(1, 1'b0, 2'd2, 1'b0, 32'd16, 32'h0, rd, er);
        check("t5_lw_16", rd, 32'h12345678);

        // Random mix of sizes, signedness, alignment and out-of-range addresses.
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(1, 0));
            r   = int'($urandom_range(7, 0));
            sz  = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
            r   = int'($urandom_range(15, 0));
            if (r == 0)      ad = $urandom;
            else if (r == 1) ad = 32'(1016 + $urandom_range(15, 0));
            else             ad = 32'($urandom_range(DEPTH - 1, 0));
            if ($urandom_range(1, 0) == 1) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            access(sel, 1'($urandom_range(1, 0)), sz, 1'($urandom_range(1, 0)), ad, $urandom, rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
